// File: rtl/ram_clr.sv
// Small single-read/single-write RAM that reloads a known pattern (DEPTH-addr) after reset
// and can be bulk-zeroed on request; requests arriving during a fill are dropped and flagged.
module ram_clr #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         rd_en,
  input  logic [A-1:0] rd_addr,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         zero_req,
  output logic [N-1:0] q,
  output logic         rd_valid,
  output logic         busy,
  output logic         rej,
  output logic [1:0]   state_dbg
);

  localparam int DEPTH = 1 << A;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    ZERO = 2'd2
  } state_t;

  // Handshake: rd_en/wr_en/zero_req are single-cycle requests sampled on the rising edge;
  // they are accepted only in IDLE. rd_valid and rej are registered one-cycle responses.
  state_t         state;
  logic [A-1:0]   cnt;
  logic [N-1:0]   mem [DEPTH];
  logic [N-1:0]   fill_val;

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_comb begin
    fill_val = '0;
    if (state == INIT) fill_val = N'(DEPTH - int'(cnt));
  end

  // Array has no reset; writes are held off while clr is asserted so INIT restarts cleanly.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (state != IDLE)
        mem[cnt] <= fill_val;
      else if (wr_en && !zero_req)
        mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= INIT;
      cnt      <= '0;
      q        <= '0;
      rd_valid <= 1'b0;
      rej      <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rej      <= 1'b0;
      case (state)
        INIT, ZERO: begin
          if (rd_en || wr_en) rej <= 1'b1;
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        IDLE: begin
          // Read uses the pre-write array contents, giving read-before-write ordering.
          if (rd_en) begin
            q        <= mem[rd_addr];
            rd_valid <= 1'b1;
          end
          if (zero_req) begin
            state <= ZERO;
            cnt   <= '0;
            if (wr_en) rej <= 1'b1;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_clr.sv
// Directed bench for ram_clr: reset reload, read/write ordering, zero fill, busy rejection
// and reset mid-fill, with hand-computed expected values.
module tb_ram_clr;

  localparam int N = 8;
  localparam int A = 3;

  logic         clk;
  logic         clr;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic         wr_en;
  logic [A-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic         zero_req;
  logic [N-1:0] q;
  logic         rd_valid;
  logic         busy;
  logic         rej;
  logic [1:0]   state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  ram_clr #(.N(N), .A(A)) dut (
    .clk(clk), .clr(clr),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .zero_req(zero_req),
    .q(q), .rd_valid(rd_valid), .busy(busy), .rej(rej),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rd_en = 1'b0; wr_en = 1'b0; zero_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k;
    k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("wait_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic read_word(input logic [A-1:0] addr, input logic [N-1:0] exp, input string tag);
    rd_en = 1'b1; rd_addr = addr;
    tick();
    rd_en = 1'b0;
    check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_q"}, {24'd0, q}, {24'd0, exp});
  endtask

  task automatic write_word(input logic [A-1:0] addr, input logic [N-1:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic check_reload(input string tag);
    for (int i = 0; i < 8; i++)
      read_word(A'(i), N'(8 - i), $sformatf("%s_a%0d", tag, i));
  endtask

  initial begin
    int cnt_busy;
    clr = 1'b1; rd_addr = '0; wr_addr = '0; wr_data = '0;
    idle_inputs();
    tick(); tick();
    check("rst_q", {24'd0, q}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rej", {31'd0, rej}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_state", {30'd0, state_dbg}, 32'd0);

    // INIT takes exactly 8 cycles after release
    clr = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("init_busy_7", {31'd0, busy}, 32'd1);
    tick();
    check("init_busy_8", {31'd0, busy}, 32'd0);
    check("idle_state", {30'd0, state_dbg}, 32'd1);
    check_reload("init");
    tick();
    check("noread_valid", {31'd0, rd_valid}, 32'd0);
    check("q_hold", {24'd0, q}, 32'd1);

    // read-before-write on the same address
    rd_en = 1'b1; rd_addr = 3'd3;
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5;
    tick();
    idle_inputs();
    check("rbw_q", {24'd0, q}, 32'd5);
    read_word(3'd3, 8'hA5, "after_wr");

    // zero fill: busy for exactly 8 cycles, then all zero
    zero_req = 1'b1;
    tick();
    zero_req = 1'b0;
    cnt_busy = 0;
    while (busy && cnt_busy < 20) begin
      cnt_busy++;
      tick();
    end
    check("zero_busy_cycles", cnt_busy, 32'd8);
    for (int i = 0; i < 8; i++) read_word(A'(i), 8'h00, $sformatf("zero_a%0d", i));

    // requests during ZERO are rejected; write to an already-filled address must not land
    zero_req = 1'b1;
    tick();
    zero_req = 1'b0;
    tick(); tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    check("busy_wr_rej", {31'd0, rej}, 32'd1);
    check("busy_wr_valid", {31'd0, rd_valid}, 32'd0);
    rd_en = 1'b1; rd_addr = 3'd0;
    tick();
    rd_en = 1'b0;
    check("busy_rd_rej", {31'd0, rej}, 32'd1);
    check("busy_rd_valid", {31'd0, rd_valid}, 32'd0);
    tick();
    check("busy_rej_clear", {31'd0, rej}, 32'd0);
    wait_idle(20);
    read_word(3'd0, 8'h00, "busy_wr_absent");

    // clr in the middle of ZERO
    write_word(3'd1, 8'h5A);
    read_word(3'd1, 8'h5A, "pre_clr");
    zero_req = 1'b1;
    tick();
    zero_req = 1'b0;
    tick(); tick(); tick();
    clr = 1'b1;
    #1;
    check("midzero_clr_q", {24'd0, q}, 32'd0);
    check("midzero_clr_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    clr = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("reinit_busy", {31'd0, busy}, 32'd0);
    check_reload("reinit");

    // zero_req + wr_en together: write dropped, rej; concurrent read sees pre-zero data
    zero_req = 1'b1;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hEE;
    rd_en = 1'b1; rd_addr = 3'd6;
    tick();
    idle_inputs();
    check("zw_rej", {31'd0, rej}, 32'd1);
    check("zw_busy", {31'd0, busy}, 32'd1);
    check("zw_rd_valid", {31'd0, rd_valid}, 32'd1);
    check("zw_rd_q", {24'd0, q}, 32'd2);
    wait_idle(20);
    read_word(3'd6, 8'h00, "zw_after");

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
